// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the configuration loader and the word-array top
// level: field encoding of the per-block bytes, array geometry constants,
// the loader state type and the field-to-strobe decode.
// No ports (package).
// ---------------------------------------------------------------------------
package cfg_pkg;

   // Field order within a block; the loader walks X, Y, AB, CX in this order
   localparam logic [1:0] F_X  = 2'd0;
   localparam logic [1:0] F_Y  = 2'd1;
   localparam logic [1:0] F_AB = 2'd2;
   localparam logic [1:0] F_CX = 2'd3;

   // Geometry of one word: 8 blocks of 4 configuration bytes
   localparam int BLOCKS_PER_WORD = 8;
   localparam int BYTES_PER_BLOCK = 4;

   // Loader state: waiting for a start request, or streaming bytes in
   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } loadState_t;

   // One-hot strobe vector {set_cx, set_ab, set_y, set_x} for a field index
   function automatic logic [3:0] fieldToStrobe(input logic [1:0] field);
      return 4'b0001 << field;
   endfunction

endpackage

// File: rtl/cfg_loader.sv
// ---------------------------------------------------------------------------
// cfg_loader
// Configuration initiator for the fabric word array. Accepts a byte stream
// over a valid/ready handshake and turns each accepted byte into exactly one
// registered write strobe (set_x / set_y / set_ab / set_cx) with its data,
// block address and word select, walking word -> block -> field in order.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset, highest priority
//   start      : one-cycle request to begin a full load (ignored in LOAD)
//   abort      : cancel a load in progress (ignored in IDLE)
//   in_data    : configuration byte from the host
//   in_valid   : in_data is valid
//   in_ready   : loader accepts a byte this cycle (LOAD and no abort)
//   cfg_in     : registered configuration byte to the words
//   cfg_addr   : registered block index within the selected word
//   word_sel   : registered index of the target word
//   set_x/y/ab/cx : registered one-hot write strobes
//   busy       : a load is in progress
//   done       : one-cycle pulse coincident with the final strobe of a load
// ---------------------------------------------------------------------------
module cfg_loader #(
   parameter int NUM_WORDS = 4,
   parameter int WSEL_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        cfg_in,
   output logic [2:0]        cfg_addr,
   output logic [WSEL_W-1:0] word_sel,
   output logic              set_x,
   output logic              set_y,
   output logic              set_ab,
   output logic              set_cx,
   output logic              busy,
   output logic              done
);

   import cfg_pkg::*;

   localparam logic [WSEL_W-1:0] LAST_WORD  = WSEL_W'(NUM_WORDS - 1);
   localparam logic [2:0]        LAST_BLOCK = 3'(BLOCKS_PER_WORD - 1);

   loadState_t        r_state;
   loadState_t        w_nextState;
   logic [WSEL_W-1:0] r_word;
   logic [2:0]        r_block;
   logic [1:0]        r_field;
   logic [3:0]        r_strobe;
   logic [7:0]        r_cfgIn;
   logic [2:0]        r_cfgAddr;
   logic [WSEL_W-1:0] r_wordSel;
   logic              r_done;
   logic              w_ready;
   logic              w_accept;
   logic              w_lastByte;

   // Handshake decode. Abort forces ready low so the byte offered in the
   // abort cycle is never consumed; this is the only input-to-output path.
   always_comb begin
      w_ready    = (r_state == LOAD) && !abort;
      w_accept   = w_ready && in_valid;
      w_lastByte = (r_word == LAST_WORD) && (r_block == LAST_BLOCK) &&
                   (r_field == F_CX);
   end

   // Next-state logic. Start wins over abort in IDLE simply because abort is
   // not looked at there; in LOAD, abort wins over a pending last byte since
   // that byte is refused anyway.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (w_accept && w_lastByte) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Position counters: field is the fastest digit, then block, then word.
   // A start in IDLE rewinds to the first byte, so an aborted load never
   // leaks its position into the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word  <= '0;
         r_block <= '0;
         r_field <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_word  <= '0;
         r_block <= '0;
         r_field <= '0;
      end else if (w_accept) begin
         r_field <= r_field + 2'd1;
         if (r_field == F_CX) begin
            r_block <= r_block + 3'd1;
            if (r_block == LAST_BLOCK) begin
               r_word <= r_word + 1'b1;
            end
         end
      end
   end

   // Output stage: every accepted byte becomes one strobe in the next cycle,
   // with its data and position captured alongside. Strobes and done are
   // pulses; data, address and word select hold between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_strobe  <= '0;
         r_cfgIn   <= '0;
         r_cfgAddr <= '0;
         r_wordSel <= '0;
         r_done    <= 1'b0;
      end else begin
         r_strobe <= '0;
         r_done   <= 1'b0;
         if (w_accept) begin
            r_strobe  <= fieldToStrobe(r_field);
            r_cfgIn   <= in_data;
            r_cfgAddr <= r_block;
            r_wordSel <= r_word;
            r_done    <= w_lastByte;
         end
      end
   end

   assign in_ready = w_ready;
   assign busy     = (r_state == LOAD);
   assign done     = r_done;
   assign cfg_in   = r_cfgIn;
   assign cfg_addr = r_cfgAddr;
   assign word_sel = r_wordSel;
   assign set_x    = r_strobe[0];
   assign set_y    = r_strobe[1];
   assign set_ab   = r_strobe[2];
   assign set_cx   = r_strobe[3];

endmodule

// File: tb/tb_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_loader
// Bench for cfg_loader. Two instances share the clock: dut0 with four words
// and dut1 with a single word. A byte-count model predicts every output each
// cycle; literal expectations on recorded strobes pin the model itself.
// ---------------------------------------------------------------------------
module tb_cfg_loader;

   logic clk;
   int   checks;
   int   errors;
   int   cycle;

   logic       rstS[2];
   logic       startS[2];
   logic       abortS[2];
   logic       validS[2];
   logic [7:0] dataS[2];

   logic       readyO[2];
   logic [7:0] cfgO[2];
   logic [2:0] addrO[2];
   logic       setX[2];
   logic       setY[2];
   logic       setAb[2];
   logic       setCx[2];
   logic       busyO[2];
   logic       doneO[2];
   logic [1:0] wsel0;
   logic [0:0] wsel1;

   // Model state: loading flag and how many bytes of the load are consumed
   logic       mLoad[2];
   int         mCount[2];
   int         mTotal[2];
   logic [3:0] eStrobe[2];
   logic [7:0] eCfg[2];
   int         eAddr[2];
   int         eWsel[2];
   logic       eDone[2];

   typedef struct {
      int         cyc;
      logic [3:0] stb;
      int         wsel;
      int         addr;
      logic [7:0] data;
      logic       done;
   } strobeRec_t;

   strobeRec_t hist0[$];
   strobeRec_t hist1[$];

   cfg_loader #(.NUM_WORDS(4)) dut0 (
      .clk(clk), .rst(rstS[0]), .start(startS[0]), .abort(abortS[0]),
      .in_data(dataS[0]), .in_valid(validS[0]), .in_ready(readyO[0]),
      .cfg_in(cfgO[0]), .cfg_addr(addrO[0]), .word_sel(wsel0),
      .set_x(setX[0]), .set_y(setY[0]), .set_ab(setAb[0]), .set_cx(setCx[0]),
      .busy(busyO[0]), .done(doneO[0])
   );

   cfg_loader #(.NUM_WORDS(1)) dut1 (
      .clk(clk), .rst(rstS[1]), .start(startS[1]), .abort(abortS[1]),
      .in_data(dataS[1]), .in_valid(validS[1]), .in_ready(readyO[1]),
      .cfg_in(cfgO[1]), .cfg_addr(addrO[1]), .word_sel(wsel1),
      .set_x(setX[1]), .set_y(setY[1]), .set_ab(setAb[1]), .set_cx(setCx[1]),
      .busy(busyO[1]), .done(doneO[1])
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // One cycle of stimulus for one instance, driven just after the edge
   task automatic applyStimulus(input int d, input logic st, input logic ab,
                                input logic v, input logic [7:0] dat);
      @(posedge clk);
      #1;
      startS[d] = st;
      abortS[d] = ab;
      validS[d] = v;
      dataS[d]  = dat;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
         applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
      end
   endtask

   // Model: the n-th byte of a load lands at word n/32, block (n/4)%8,
   // field n%4, and the last byte of the load raises done with its strobe
   always @(posedge clk) begin
      cycle++;
      for (int d = 0; d < 2; d++) begin
         if (rstS[d]) begin
            mLoad[d]   = 1'b0;
            mCount[d]  = 0;
            eStrobe[d] = 4'b0000;
            eCfg[d]    = 8'h00;
            eAddr[d]   = 0;
            eWsel[d]   = 0;
            eDone[d]   = 1'b0;
         end else begin
            eStrobe[d] = 4'b0000;
            eDone[d]   = 1'b0;
            if (!mLoad[d]) begin
               if (startS[d]) begin
                  mLoad[d]  = 1'b1;
                  mCount[d] = 0;
               end
            end else if (abortS[d]) begin
               mLoad[d] = 1'b0;
            end else if (validS[d]) begin
               eStrobe[d] = 4'b0001 << (mCount[d] % 4);
               eCfg[d]    = dataS[d];
               eAddr[d]   = (mCount[d] / 4) % 8;
               eWsel[d]   = mCount[d] / 32;
               mCount[d]  = mCount[d] + 1;
               if (mCount[d] == mTotal[d]) begin
                  mLoad[d] = 1'b0;
                  eDone[d] = 1'b1;
               end
            end
         end
      end
   end

   // Compare every output of both instances against the model mid-cycle,
   // and log each observed strobe for the literal checks
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [3:0] actStb;
         int         actW;
         strobeRec_t rec;
         actStb = {setCx[d], setAb[d], setY[d], setX[d]};
         actW   = (d == 0) ? int'(wsel0) : int'(wsel1);
         checkOutput($sformatf("dut%0d in_ready", d), int'(readyO[d]), int'(mLoad[d] && !abortS[d]));
         checkOutput($sformatf("dut%0d busy", d), int'(busyO[d]), int'(mLoad[d]));
         checkOutput($sformatf("dut%0d done", d), int'(doneO[d]), int'(eDone[d]));
         checkOutput($sformatf("dut%0d strobes", d), int'(actStb), int'(eStrobe[d]));
         checkOutput($sformatf("dut%0d cfg_in", d), int'(cfgO[d]), int'(eCfg[d]));
         checkOutput($sformatf("dut%0d cfg_addr", d), int'(addrO[d]), eAddr[d]);
         checkOutput($sformatf("dut%0d word_sel", d), actW, eWsel[d]);
         if (actStb != 4'b0000) begin
            rec.cyc  = cycle;
            rec.stb  = actStb;
            rec.wsel = actW;
            rec.addr = int'(addrO[d]);
            rec.data = cfgO[d];
            rec.done = doneO[d];
            if (d == 0) hist0.push_back(rec);
            else        hist1.push_back(rec);
         end
      end
   end

   // Directed scenario sequence
   initial begin
      int gaps;
      int doneSeen;
      int badWsel;
      checks    = 0;
      errors    = 0;
      cycle     = 0;
      mTotal[0] = 128;
      mTotal[1] = 32;
      for (int d = 0; d < 2; d++) begin
         rstS[d] = 1'b1; startS[d] = 1'b0; abortS[d] = 1'b0;
         validS[d] = 1'b0; dataS[d] = 8'h00;
         mLoad[d] = 1'b0; mCount[d] = 0; eStrobe[d] = 4'b0000;
         eCfg[d] = 8'h00; eAddr[d] = 0; eWsel[d] = 0; eDone[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", int'(busyO[0]), 0);
      checkOutput("reset in_ready", int'(readyO[0]), 0);
      checkOutput("reset cfg_in", int'(cfgO[0]), 0);
      rstS[0] = 1'b0;
      rstS[1] = 1'b0;

      // Valid bytes while idle are ignored
      hist0.delete();
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'hAA);
      idleCycles(2);
      checkOutput("idle valid strobes", hist0.size(), 0);

      // Full back-to-back load
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 128; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'(i));
      idleCycles(3);
      checkOutput("full count", hist0.size(), 128);
      if (hist0.size() == 128) begin
         checkOutput("full span", hist0[127].cyc - hist0[0].cyc, 127);
         checkOutput("byte 0x25 strobe", int'(hist0[37].stb), 2);
         checkOutput("byte 0x25 word", hist0[37].wsel, 1);
         checkOutput("byte 0x25 addr", hist0[37].addr, 1);
         checkOutput("byte 0x25 data", int'(hist0[37].data), 'h25);
         checkOutput("byte 0x26 strobe", int'(hist0[38].stb), 4);
         checkOutput("last strobe", int'(hist0[127].stb), 8);
         checkOutput("last word", hist0[127].wsel, 3);
         checkOutput("last addr", hist0[127].addr, 7);
         checkOutput("last data", int'(hist0[127].data), 'h7F);
         checkOutput("last done", int'(hist0[127].done), 1);
      end
      checkOutput("busy after full", int'(busyO[0]), 0);

      // Throttled source: one idle cycle between strobes
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 128; i++) begin
         applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'(i));
         applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'hFF);
      end
      idleCycles(3);
      checkOutput("throttle count", hist0.size(), 128);
      gaps = 0;
      for (int i = 1; i < hist0.size(); i++) begin
         if (hist0[i].cyc - hist0[i-1].cyc != 2) gaps++;
      end
      checkOutput("throttle gaps", gaps, 0);

      // Abort after ten bytes, with a byte offered in the abort cycle
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 8'hEE);
      idleCycles(3);
      checkOutput("abort count", hist0.size(), 10);
      doneSeen = 0;
      foreach (hist0[i]) if (hist0[i].done) doneSeen++;
      checkOutput("abort done", doneSeen, 0);
      if (hist0.size() == 10) begin
         checkOutput("abort last strobe", int'(hist0[9].stb), 2);
         checkOutput("abort last addr", hist0[9].addr, 2);
      end
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'h55);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
      idleCycles(2);
      checkOutput("restart count", hist0.size(), 1);
      if (hist0.size() == 1) begin
         checkOutput("restart strobe", int'(hist0[0].stb), 1);
         checkOutput("restart word", hist0[0].wsel, 0);
         checkOutput("restart addr", hist0[0].addr, 0);
      end

      // Start pulsed mid-load is ignored
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 128; i++) applyStimulus(0, i == 20, 1'b0, 1'b1, 8'(255 - i));
      idleCycles(3);
      checkOutput("mid start count", hist0.size(), 128);
      if (hist0.size() == 128) checkOutput("mid start done", int'(hist0[127].done), 1);

      // Reset in the cycle after the 50th accept
      hist0.delete();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 50; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'(i + 1));
      @(posedge clk);
      #1;
      rstS[0]   = 1'b1;
      validS[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst strobe count", hist0.size(), 50);
      checkOutput("rst strobes", int'({setCx[0], setAb[0], setY[0], setX[0]}), 0);
      checkOutput("rst cfg_in", int'(cfgO[0]), 0);
      checkOutput("rst cfg_addr", int'(addrO[0]), 0);
      checkOutput("rst word_sel", int'(wsel0), 0);
      checkOutput("rst busy", int'(busyO[0]), 0);
      rstS[0] = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'h77);
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
      idleCycles(2);

      // Single-word instance: 32 bytes, word_sel stays 0
      hist1.delete();
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 32; i++) applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'(8'hA0 + i));
      idleCycles(3);
      checkOutput("one word count", hist1.size(), 32);
      badWsel = 0;
      foreach (hist1[i]) if (hist1[i].wsel != 0) badWsel++;
      checkOutput("one word wsel", badWsel, 0);
      if (hist1.size() == 32) begin
         checkOutput("one word last strobe", int'(hist1[31].stb), 8);
         checkOutput("one word last addr", hist1[31].addr, 7);
         checkOutput("one word done", int'(hist1[31].done), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
